// File: rtl/cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_ctrl
// Purpose  : Memory-side controller for a write-through cache. Stores are
//            queued in a small write buffer and drained to memory ahead of any
//            read, so a refill always observes earlier stores. A single read
//            miss can be outstanding; its refill word is returned to the cache
//            as a one-cycle fill pulse.
// Ports    : clk, rst                          - clock, async active-high reset
//            miss_req, miss_addr               - cache read miss request
//            write_en, write_addr, write_data  - write-through store
//            fill_valid, fill_addr, fill_data  - refill pulse to the cache
//            stall                             - cache must hold its request
//            mem_req, mem_we, mem_addr,
//            mem_wdata, mem_ready              - memory request channel
//            mem_rvalid, mem_rdata             - memory read return
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                    c_PTR_W     = $clog2(WB_DEPTH);
    localparam logic [c_PTR_W:0]      c_WB_FULL   = (c_PTR_W + 1)'(WB_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_WORD_MASK = ~(ADDR_WIDTH'(3));

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WR    = 3'd1;
    localparam logic [2:0] c_RD    = 3'd2;
    localparam logic [2:0] c_RWAIT = 3'd3;
    localparam logic [2:0] c_FILL  = 3'd4;

    logic [2:0]            r_state;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_miss_addr;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [ADDR_WIDTH-1:0] r_wb_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] r_wb_data [WB_DEPTH];

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;

    // A full buffer refuses the store outright; a same-cycle pop does not
    // make room for it.
    assign w_full      = (r_count == c_WB_FULL);
    assign w_push      = write_en && !w_full;
    assign w_pop       = (r_state == c_WR) && mem_ready;
    assign w_head_addr = r_wb_addr[r_rd_ptr];
    assign w_head_data = r_wb_data[r_rd_ptr];

    // Buffer storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= write_addr;
            r_wb_data[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pending   <= 1'b0;
            r_miss_addr <= '0;
            r_rdata     <= '0;
        end else begin
            // Pointers wrap naturally because WB_DEPTH is a power of two.
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase

            // pending is always set while in FILL, so a new miss can never
            // be latched in the same cycle the old one retires.
            if (miss_req && !r_pending) begin
                r_miss_addr <= miss_addr & c_WORD_MASK;
                r_pending   <= 1'b1;
            end else if (r_state == c_FILL) begin
                r_pending   <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    // Drain buffered stores first to keep read-after-write order.
                    if (r_count != '0)   r_state <= c_WR;
                    else if (r_pending)  r_state <= c_RD;
                end
                c_WR: begin
                    if (mem_ready) r_state <= c_IDLE;
                end
                c_RD: begin
                    if (mem_ready) r_state <= c_RWAIT;
                end
                c_RWAIT: begin
                    if (mem_rvalid) begin
                        r_rdata <= mem_rdata;
                        r_state <= c_FILL;
                    end
                end
                c_FILL: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign stall = r_pending || w_full;

    // Memory and fill outputs are pure decodes of registered state.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_addr  = '0;
        fill_data  = '0;
        case (r_state)
            c_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_head_addr & c_WORD_MASK;
                mem_wdata = w_head_data;
            end
            c_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_miss_addr;
            end
            c_FILL: begin
                fill_valid = 1'b1;
                fill_addr  = r_miss_addr;
                fill_data  = r_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_ctrl
// Purpose  : Scoreboard bench for cache_mem_ctrl. Directed scenarios push the
//            memory transactions and fills they expect; a negedge monitor pops
//            and compares whenever the DUT issues an accepted memory request
//            or a fill pulse. A small memory model returns read data a fixed
//            number of cycles after a read is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        write_en;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    cache_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } fill_t;

    mem_t  exp_mem[$];
    fill_t exp_fill[$];
    int    wr_acc_q[$];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rv_at    = -100;
    int          rd_lat   = 1;
    logic        model_rv = 1'b0;
    logic        force_rv = 1'b0;
    logic [31:0] rd_data  = '0;

    assign mem_rvalid = model_rv | force_rv;
    assign mem_rdata  = rd_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: rvalid for one cycle, rd_lat cycles after acceptance.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        model_rv = (cyc == rv_at);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            if (!mem_we) rv_at = cyc + rd_lat;
            else         wr_acc_q.push_back(cyc);
            if (exp_mem.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_unexpected: got we=%0b addr=%h wdata=%h expected no request", mem_we, mem_addr, mem_wdata);
            end else begin
                mem_t e;
                e = exp_mem.pop_front();
                check("mem_we",    {63'd0, mem_we}, {63'd0, e.we});
                check("mem_addr",  {32'd0, mem_addr}, {32'd0, e.addr});
                check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
            end
        end
        if (fill_valid) begin
            if (exp_fill.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fill_unexpected: got addr=%h data=%h expected no fill", fill_addr, fill_data);
            end else begin
                fill_t f;
                f = exp_fill.pop_front();
                check("fill_addr", {32'd0, fill_addr}, {32'd0, f.addr});
                check("fill_data", {32'd0, fill_data}, {32'd0, f.data});
                if (f.cyc >= 0) check("fill_cycle", 64'(cyc), 64'(f.cyc));
            end
        end
    end

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_mem.size() != 0 || exp_fill.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: got mem=%0d fill=%0d outstanding expected 0", tag, exp_mem.size(), exp_fill.size());
            exp_mem.delete();
            exp_fill.delete();
        end
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int k;
        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; write_en = 1'b0;
        write_addr = '0; write_data = '0; mem_ready = 1'b0;
        #2;
        // Reset state, before any clock edge.
        check("rst_fill_valid", {63'd0, fill_valid}, 64'd0);
        check("rst_fill_addr",  {32'd0, fill_addr},  64'd0);
        check("rst_fill_data",  {32'd0, fill_data},  64'd0);
        check("rst_stall",      {63'd0, stall},      64'd0);
        check("rst_mem_req",    {63'd0, mem_req},    64'd0);
        check("rst_mem_we",     {63'd0, mem_we},     64'd0);
        check("rst_mem_addr",   {32'd0, mem_addr},   64'd0);
        check("rst_mem_wdata",  {32'd0, mem_wdata},  64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic miss with minimum latency.
        mem_ready = 1'b1; rd_lat = 1; rd_data = 32'hDEADBEEF;
        k = cyc;
        miss_req = 1'b1; miss_addr = 32'h0000_1007;
        exp_mem.push_back('{we: 1'b0, addr: 32'h0000_1004, data: 32'h0});
        exp_fill.push_back('{addr: 32'h0000_1004, data: 32'hDEADBEEF, cyc: k + 4});
        tick();
        miss_req = 1'b0;
        check("miss_stall", {63'd0, stall}, 64'd1);
        wait_drain("miss");
        check("miss_stall_after", {63'd0, stall}, 64'd0);

        // Fill the write buffer while memory is busy, overflow, then drain.
        mem_ready = 1'b0;
        wr_acc_q.delete();
        for (int i = 0; i < 4; i++) begin
            write_en   = 1'b1;
            write_addr = 32'h10 + 32'(i * 4);
            write_data = 32'hA + 32'(i);
            exp_mem.push_back('{we: 1'b1, addr: 32'h10 + 32'(i * 4), data: 32'hA + 32'(i)});
            tick();
        end
        check("wb_full_stall", {63'd0, stall}, 64'd1);
        write_addr = 32'h24; write_data = 32'hE;
        tick();
        check("wb_full_stall2", {63'd0, stall}, 64'd1);
        // Write while full in the same cycle as the first pop: still dropped.
        write_addr = 32'h28; write_data = 32'hF; mem_ready = 1'b1;
        tick();
        write_en = 1'b0;
        wait_drain("wb");
        check("wb_drain_count", 64'(wr_acc_q.size()), 64'd4);
        for (int i = 1; i < 4 && i < wr_acc_q.size(); i++)
            check("wb_drain_gap", 64'(wr_acc_q[i] - wr_acc_q[i-1]), 64'd2);
        check("wb_stall_after", {63'd0, stall}, 64'd0);

        // Store and miss to the same word in one cycle: write goes first.
        rd_data = 32'h1234_5678;
        write_en = 1'b1; write_addr = 32'h20; write_data = 32'h55;
        miss_req = 1'b1; miss_addr = 32'h20;
        exp_mem.push_back('{we: 1'b1, addr: 32'h20, data: 32'h55});
        exp_mem.push_back('{we: 1'b0, addr: 32'h20, data: 32'h0});
        exp_fill.push_back('{addr: 32'h20, data: 32'h1234_5678, cyc: -1});
        tick();
        write_en = 1'b0; miss_req = 1'b0;
        wait_drain("raw");

        // Second miss while one is pending is ignored; stall holds to FILL.
        mem_ready = 1'b0; rd_data = 32'hCAFE_F00D;
        miss_req = 1'b1; miss_addr = 32'h43;
        exp_mem.push_back('{we: 1'b0, addr: 32'h40, data: 32'h0});
        exp_fill.push_back('{addr: 32'h40, data: 32'hCAFE_F00D, cyc: -1});
        tick();
        miss_addr = 32'h80;
        tick();
        miss_req = 1'b0;
        check("dup_miss_stall", {63'd0, stall}, 64'd1);
        repeat (3) tick();
        check("dup_miss_stall_hold", {63'd0, stall}, 64'd1);
        mem_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (fill_valid) seen = 1'b1;
            check("dup_miss_stall_loop", {63'd0, stall}, 64'd1);
        end
        check("dup_miss_fill_seen", {63'd0, seen}, 64'd1);
        tick();
        check("dup_miss_stall_clear", {63'd0, stall}, 64'd0);
        wait_drain("dup");

        // Reset while waiting for read data; late rvalid must not fill.
        rd_lat = 3; rd_data = 32'hBAD0_BAD0;
        miss_req = 1'b1; miss_addr = 32'h100;
        exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: 32'h0});
        tick();
        miss_req = 1'b0;
        k = 0;
        while (exp_mem.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        check("rwait_reached", 64'(exp_mem.size()), 64'd0);
        rst = 1'b1;
        #1;
        check("rwait_rst_mem_req", {63'd0, mem_req},    64'd0);
        check("rwait_rst_stall",   {63'd0, stall},      64'd0);
        check("rwait_rst_fill",    {63'd0, fill_valid}, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_fill", {63'd0, fill_valid}, 64'd0);
        end
        check("post_rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("post_rst_stall",   {63'd0, stall},   64'd0);
        rd_lat = 1;

        // Stray rvalid while idle.
        force_rv = 1'b1; rd_data = 32'h7777_7777;
        tick();
        tick();
        force_rv = 1'b0;
        check("idle_rv_fill",    {63'd0, fill_valid}, 64'd0);
        check("idle_rv_mem_req", {63'd0, mem_req},    64'd0);
        repeat (3) tick();
        check("idle_rv_fill2",   {63'd0, fill_valid}, 64'd0);
        check("idle_rv_stall",   {63'd0, stall},      64'd0);

        wait_drain("end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
